// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one common-anode digit lit at a time, dark guard between digits.
// Latency: an/seg/frame_done are registered on the same edge as the scan state change; new data lands at frame boundaries.
// Backpressure: none; load is a fire-and-forget strobe, and the last load before a boundary wins.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   load, digits_in, en_in   strobe capturing per-digit hex nibbles and enables
//   an                       active-low anode drives, at most one low per cycle
//   seg                      active-low segments {g,f,e,d,c,b,a}
//   frame_done               one-cycle pulse during the first SHOW cycle of digit 0
module display_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int DIV_COUNT    = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   en_in,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  frame_done
);

  localparam int MAX_CNT = (DIV_COUNT > BLANK_CYCLES) ? DIV_COUNT : BLANK_CYCLES;
  localparam int CTR_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CTR_W-1:0] SHOW_LAST  = CTR_W'(DIV_COUNT - 1);
  localparam logic [CTR_W-1:0] BLANK_LAST = CTR_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  state_t                     state_q, state_d;
  logic [CTR_W-1:0]           ctr_q, ctr_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [N_DIGITS-1:0][3:0]   shd_dig_q, shd_dig_d;
  logic [N_DIGITS-1:0]        shd_en_q, shd_en_d;
  logic [N_DIGITS-1:0][3:0]   pnd_dig_q, pnd_dig_d;
  logic [N_DIGITS-1:0]        pnd_en_q, pnd_en_d;
  logic                       pnd_vld_q, pnd_vld_d;
  logic [N_DIGITS-1:0]        an_q, an_d;
  logic [6:0]                 seg_q, seg_d;
  logic                       fd_q, fd_d;
  logic                       boundary;

  // A frame starts when the guard after the last digit expires.
  assign boundary = (state_q == ST_BLANK) && (ctr_q == BLANK_LAST) && (idx_q == IDX_LAST);

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    idx_d     = idx_q;
    shd_dig_d = shd_dig_q;
    shd_en_d  = shd_en_q;
    pnd_dig_d = pnd_dig_q;
    pnd_en_d  = pnd_en_q;
    pnd_vld_d = pnd_vld_q;
    an_d      = '1;
    seg_d     = 7'h7F;
    fd_d      = boundary;

    if (state_q == ST_BLANK) begin
      if (ctr_q == BLANK_LAST) begin
        ctr_d   = '0;
        state_d = ST_SHOW;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        ctr_d = ctr_q + 1'b1;
      end
    end else begin
      if (ctr_q == SHOW_LAST) begin
        ctr_d   = '0;
        state_d = ST_BLANK;
      end else begin
        ctr_d = ctr_q + 1'b1;
      end
    end

    // A load on the boundary edge skips the pending stage so it shows this frame.
    if (load) begin
      if (boundary) begin
        shd_dig_d = digits_in;
        shd_en_d  = en_in;
        pnd_vld_d = 1'b0;
      end else begin
        pnd_dig_d = digits_in;
        pnd_en_d  = en_in;
        pnd_vld_d = 1'b1;
      end
    end else if (boundary && pnd_vld_q) begin
      shd_dig_d = pnd_dig_q;
      shd_en_d  = pnd_en_q;
      pnd_vld_d = 1'b0;
    end

    // Outputs are decoded from next state so they change on the transition edge itself.
    // A disabled digit still consumes its dwell, it just stays dark.
    if ((state_d == ST_SHOW) && shd_en_d[idx_d]) begin
      an_d[idx_d] = 1'b0;
      seg_d       = hex7(shd_dig_d[idx_d]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_BLANK;
      ctr_q     <= '0;
      idx_q     <= IDX_LAST;
      shd_dig_q <= '0;
      shd_en_q  <= '0;
      pnd_dig_q <= '0;
      pnd_en_q  <= '0;
      pnd_vld_q <= 1'b0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      idx_q     <= idx_d;
      shd_dig_q <= shd_dig_d;
      shd_en_q  <= shd_en_d;
      pnd_dig_q <= pnd_dig_d;
      pnd_en_q  <= pnd_en_d;
      pnd_vld_q <= pnd_vld_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      fd_q      <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with a frame-arithmetic reference model.
// Latency: expected outputs are queued per edge by the driver and popped by the monitor after each edge.
// Backpressure: none; the DUT produces one observation every cycle.
module tb_display_scan_ctrl;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int B  = 2;
  localparam int P  = D + B;
  localparam int FP = N * P;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  en_in = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .N_DIGITS    (N),
    .DIV_COUNT   (D),
    .BLANK_CYCLES(B)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .digits_in (digits_in),
    .en_in     (en_in),
    .an        (an),
    .seg       (seg),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
  } obs_t;

  int total = 0;
  int bad   = 0;

  obs_t        exp_q[$];
  int          ld_edge[$];
  logic [15:0] ld_dig[$];
  logic [3:0]  ld_en[$];
  int          edge_n = 0;
  bit          mon_en = 1'b0;

  logic [6:0] hex_ref [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Expected outputs after edge e (edge 1 = first rising edge with rst low).
  // Frames start at edges B, B+FP, ...; a frame displays the most recent load
  // captured on or before its starting edge.
  function automatic obs_t model(input int e);
    obs_t        o;
    int          s, f, r, dg, q, bedge;
    logic [15:0] sd;
    logic [3:0]  se;
    o.an  = 4'hF;
    o.seg = 7'h7F;
    o.fd  = 1'b0;
    if (e < B) return o;
    s     = e - B;
    f     = s / FP;
    r     = s % FP;
    dg    = r / P;
    q     = r % P;
    bedge = B + f * FP;
    o.fd  = (r == 0);
    sd = '0;
    se = '0;
    foreach (ld_edge[i]) begin
      if (ld_edge[i] <= bedge) begin
        sd = ld_dig[i];
        se = ld_en[i];
      end
    end
    if (q < D && se[dg]) begin
      o.an[dg] = 1'b0;
      o.seg    = hex_ref[sd[dg*4 +: 4]];
    end
    return o;
  endfunction

  function automatic int next_boundary();
    int k = 0;
    while (B + k * FP <= edge_n) k++;
    return B + k * FP;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (edge %0d)", name, act, expv, edge_n);
    end
  endtask

  // Called at a falling edge: drives inputs for the coming rising edge,
  // queues the expected result of that edge, then waits for the next falling edge.
  task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] en);
    load      = ld;
    digits_in = ld ? d  : 16'($urandom);
    en_in     = ld ? en : 4'($urandom);
    edge_n++;
    if (ld) begin
      ld_edge.push_back(edge_n);
      ld_dig.push_back(d);
      ld_en.push_back(en);
    end
    exp_q.push_back(model(edge_n));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0, 4'h0);
  endtask

  // Makes the load land exactly on the next frame-boundary edge.
  task automatic load_on_boundary(input logic [15:0] d, input logic [3:0] en);
    int nb;
    nb = next_boundary();
    while (edge_n < nb - 1) step(1'b0, 16'h0, 4'h0);
    step(1'b1, d, en);
  endtask

  task automatic reset_hold(input int cycles);
    mon_en = 1'b0;
    rst    = 1'b1;
    load   = 1'b0;
    #1;
    check("rst_an", int'(an), 32'hF);
    check("rst_seg", int'(seg), 32'h7F);
    check("rst_fd", int'(frame_done), 0);
    repeat (cycles) begin
      @(negedge clk);
      check("rst_hold_an", int'(an), 32'hF);
      check("rst_hold_seg", int'(seg), 32'h7F);
    end
    exp_q.delete();
    ld_edge.delete();
    ld_dig.delete();
    ld_en.delete();
    edge_n = 0;
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  // Monitor: one observation per rising edge while the scan is running.
  initial begin
    obs_t a, x;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        a = {an, seg, frame_done};
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_empty: actual=observation required=queued expectation (edge %0d)", edge_n);
        end else begin
          x = exp_q.pop_front();
          check("scan", int'(a), int'(x));
        end
        check("anode_overlap", ($countones(~an) <= 1) ? 1 : 0, 1);
      end
    end
  end

  initial begin
    int nb;
    @(negedge clk);
    reset_hold(3);

    // Load before the first boundary: visible on digit 0 right after it.
    step(1'b1, 16'h3210, 4'hF);
    idle(48);

    // Mid-frame load must not tear the current frame.
    while (edge_n < 59) step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'hFFFF, 4'hF);
    idle(48);

    // Enable mask keeps frame timing but darkens digits 1 and 3.
    step(1'b1, 16'h3210, 4'b0101);
    idle(50);

    // Last load before a boundary wins.
    step(1'b1, 16'h1111, 4'hF);
    idle(3);
    step(1'b1, 16'h2222, 4'hF);
    idle(FP + 4);

    // Load on the boundary edge bypasses the pending stage.
    load_on_boundary(16'hABCD, 4'hF);
    idle(FP);

    // Remaining hex codes.
    step(1'b1, 16'hFEDC, 4'hF);
    idle(2 * FP);
    step(1'b1, 16'hBA98, 4'hF);
    idle(2 * FP);
    step(1'b1, 16'h7654, 4'hF);
    idle(2 * FP);

    // Reset mid-SHOW: dark at once, buffers discarded afterwards.
    nb = next_boundary();
    while (edge_n < nb + 1) step(1'b0, 16'h0, 4'h0);
    reset_hold(3);
    idle(FP + 6);

    // Random loads, including some landing on boundary edges.
    repeat (1500) begin
      step(($urandom_range(0, 19) == 0), 16'($urandom), 4'($urandom));
    end
    idle(4);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
